// File: rtl/cache_mem_ctrl.sv
// Line-oriented backing memory for a cache controller: 16 lines, fixed-latency
// refill/write-back handshake with a one-cycle completion pulse.
module cache_mem_ctrl #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 128,
    parameter int MEM_LATENCY   = 4,
    parameter int INIT_MEM      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_req,
    input  logic                     mem_we,
    input  logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [BLOCK_SIZE-1:0]    mem_wdata,
    output logic                     mem_ready,
    output logic                     mem_valid,
    output logic [BLOCK_SIZE-1:0]    mem_rdata
);

    localparam int NUM_LINES     = 16;
    localparam int LINE_BYTES    = 16;
    localparam int BYTES_PER_WRD = DATA_WIDTH / 8;
    localparam int WORDS         = BLOCK_SIZE / DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  w_accept;
    logic                  w_finish;
    logic                  r_we;
    logic [3:0]            r_idx;
    logic [BLOCK_SIZE-1:0] r_wdata;
    logic [BLOCK_SIZE-1:0] r_rdata;
    logic [BLOCK_SIZE-1:0] r_mem  [NUM_LINES];
    logic [BLOCK_SIZE-1:0] w_init [NUM_LINES];
    logic                  w_unused_addr;

    // Only the line index mem_addr[7:4] selects storage.
    assign w_unused_addr = ^mem_addr;

    // Reset image of one line: each byte holds its own byte address.
    function automatic logic [BLOCK_SIZE-1:0] init_line(input int idx);
        logic [BLOCK_SIZE-1:0] line;
        line = '0;
        if (INIT_MEM != 0) begin
            for (int w = 0; w < WORDS; w++) begin
                for (int b = 0; b < BYTES_PER_WRD; b++) begin
                    line[(w*BYTES_PER_WRD + b)*8 +: 8] =
                        8'(idx*LINE_BYTES + w*BYTES_PER_WRD + b);
                end
            end
        end
        return line;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_init
            assign w_init[gi] = init_line(gi);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        mem_ready    = 1'b0;
        mem_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                mem_ready = 1'b1;
                if (mem_req) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = 4'(MEM_LATENCY - 1);
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_finish     = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                mem_valid    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request fields are frozen at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_we    <= 1'b0;
            r_idx   <= 4'd0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= mem_we;
            r_idx   <= mem_addr[7:4];
            r_wdata <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_mem[i] <= w_init[i];
            end
        end else if (w_finish && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rdata <= '0;
        end else if (w_finish && !r_we) begin
            r_rdata <= r_mem[r_idx];
        end
    end

    assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed plus randomized checks of cache_mem_ctrl against a line-array model,
// using three instances (latency 4 / latency 1 / zero-initialized latency 3).
module tb_cache_mem_ctrl;

    logic         clk;
    logic         rst_n;
    logic         req;
    int           sel;
    logic         we;
    logic [7:0]   addr;
    logic [127:0] wdata;

    logic         req_a, req_b, req_c;
    logic         ready_a, ready_b, ready_c;
    logic         valid_a, valid_b, valid_c;
    logic [127:0] rdata_a, rdata_b, rdata_c;
    logic         cur_ready, cur_valid;
    logic [127:0] cur_rdata;

    int checks = 0;
    int fails  = 0;
    int ntxn   = 0;

    logic [127:0] ref_mem   [3][16];
    logic [127:0] ref_rdata [3];
    int           lat_of    [3] = '{4, 1, 3};
    int           init_of   [3] = '{1, 1, 0};

    assign req_a = req && (sel == 0);
    assign req_b = req && (sel == 1);
    assign req_c = req && (sel == 2);

    cache_mem_ctrl #(.MEM_LATENCY(4), .INIT_MEM(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .mem_req(req_a), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata), .mem_ready(ready_a), .mem_valid(valid_a), .mem_rdata(rdata_a));

    cache_mem_ctrl #(.MEM_LATENCY(1), .INIT_MEM(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .mem_req(req_b), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata), .mem_ready(ready_b), .mem_valid(valid_b), .mem_rdata(rdata_b));

    cache_mem_ctrl #(.MEM_LATENCY(3), .INIT_MEM(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .mem_req(req_c), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata), .mem_ready(ready_c), .mem_valid(valid_c), .mem_rdata(rdata_c));

    always_comb begin
        cur_ready = ready_a;
        cur_valid = valid_a;
        cur_rdata = rdata_a;
        case (sel)
            1: begin cur_ready = ready_b; cur_valid = valid_b; cur_rdata = rdata_b; end
            2: begin cur_ready = ready_c; cur_valid = valid_c; cur_rdata = rdata_c; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Every byte of the address space holds its own address (or zero).
    function automatic logic [127:0] pattern(input int line, input int init);
        logic [127:0] v;
        v = '0;
        if (init != 0) begin
            for (int b = 0; b < 16; b++) v[8*b +: 8] = 8'(line*16 + b);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < 16; l++) ref_mem[k][l] = pattern(l, init_of[k]);
            ref_rdata[k] = '0;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one transfer from a negedge; returns at the negedge where mem_valid is seen.
    task automatic txn(input int s, input logic w, input logic [7:0] a,
                       input logic [127:0] d, input bit scramble);
        int n;
        int k;
        int lat;
        sel = s; we = w; addr = a; wdata = d; req = 1'b1;
        n = 0;
        while (!cur_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", 128'(cur_ready), 128'(1));
        if (!cur_ready) begin
            req = 1'b0;
            return;
        end
        @(posedge clk);
        k = 0;
        lat = -1;
        while (k < 40) begin
            @(negedge clk);
            if (cur_valid) begin
                lat = k;
                break;
            end
            if (k == 0) chk("busy_not_ready", 128'(cur_ready), 128'(0));
            if (scramble) begin
                req   = 1'($urandom);
                we    = 1'($urandom);
                addr  = 8'($urandom);
                wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            k++;
        end
        chk("latency", 128'(lat), 128'(lat_of[s]));
        if (w) ref_mem[s][a[7:4]] = d;
        else   ref_rdata[s] = ref_mem[s][a[7:4]];
        chk("rdata", cur_rdata, ref_rdata[s]);
        req = 1'b0;
        ntxn++;
        $display("txn %0d dut=%0d we=%0d addr=%h lat=%0d rdata=%h", ntxn, s, w, a, lat, cur_rdata);
    endtask

    initial begin
        logic [7:0]   ra;
        logic [127:0] rd;
        logic         rw;
        req = 1'b0; sel = 0; we = 1'b0; addr = '0; wdata = '0;
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_ready", 128'(ready_a), 128'(1));
        chk("reset_valid", 128'(valid_a), 128'(0));
        chk("reset_rdata", rdata_a, '0);
        rst_n = 1'b0;

        // First request after release, then the line-1 refill.
        txn(0, 1'b0, 8'h10, '0, 1'b0);
        chk("read_0x10", rdata_a, 128'h1F1E1D1C_1B1A1918_17161514_13121110);

        // Write-back leaves rdata alone; read of the same line returns it.
        txn(0, 1'b1, 8'h90, {4{32'hCAFEBABE}}, 1'b0);
        chk("write_keeps_rdata", rdata_a, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
        txn(0, 1'b0, 8'h9C, '0, 1'b0);
        chk("read_0x9C", rdata_a, {4{32'hCAFEBABE}});

        // Input churn during WAIT must not disturb the transfer.
        txn(0, 1'b0, 8'h30, '0, 1'b1);
        chk("churn_word0", 128'(rdata_a[31:0]), 128'(32'h33323130));
        @(negedge clk);
        chk("churn_no_extra", 128'(valid_a), 128'(0));

        // Reset two cycles into a write aborts it.
        sel = 0; we = 1'b1; addr = 8'h70; wdata = {4{32'hDEADBEEF}}; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("abort_ready", 128'(ready_a), 128'(1));
        chk("abort_valid", 128'(valid_a), 128'(0));
        chk("abort_rdata", rdata_a, '0);
        model_reset();
        repeat (6) @(posedge clk);
        #1 chk("abort_no_pulse", 128'(valid_a), 128'(0));
        @(negedge clk);
        rst_n = 1'b0;
        txn(0, 1'b0, 8'h70, '0, 1'b0);
        chk("abort_word0", 128'(rdata_a[31:0]), 128'(32'h73727170));

        // Latency 1, back-to-back refills.
        txn(1, 1'b0, 8'h00, '0, 1'b0);
        chk("b2b_first", 128'(rdata_b[31:0]), 128'(32'h03020100));
        txn(1, 1'b0, 8'hF0, '0, 1'b0);
        chk("b2b_second", 128'(rdata_b[31:0]), 128'(32'hF3F2F1F0));

        // Zero-initialized storage.
        txn(2, 1'b0, 8'h50, '0, 1'b0);
        chk("zero_init", rdata_c, '0);

        // Randomized traffic, including write followed directly by read of that line.
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom);
            rd = {$urandom, $urandom, $urandom, $urandom};
            rw = 1'($urandom);
            txn(int'($urandom_range(0, 2)), rw, ra, rd, 1'($urandom));
            if (rw && ($urandom_range(0, 1) == 1)) txn(sel, 1'b0, {ra[7:4], 4'($urandom)}, '0, 1'b0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_ctrl.md
CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 8, meaning the byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the word width (bits).
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 128, meaning the line width (bits) transferred per request.
REQ-004 The block SHALL have parameter MEM_LATENCY, default 4, legal range 1..15, meaning cycles from request acceptance to completion.
REQ-005 The block SHALL have parameter INIT_MEM, default 1, meaning 1 = load the byte-address pattern at reset and 0 = load zeros.
REQ-006 The block SHALL have port clk, input, 1, meaning the clock, with all state updated on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, meaning the reset, which is asynchronous and active-high.
REQ-008 The block SHALL have port mem_req, input, 1, meaning the line transfer request from the cache controller.
REQ-009 The block SHALL have port mem_we, input, 1, meaning 1 = line write-back and 0 = line refill read.
REQ-010 The block SHALL have port mem_addr, input, ADDRESS_WIDTH, meaning the byte address, of which only bits [7:4] (line index, 16 lines) are used.
REQ-011 The block SHALL have port mem_wdata, input, BLOCK_SIZE, meaning the write-back line, with word 0 in [31:0] and word 3 in [127:96].
REQ-012 The block SHALL have port mem_ready, output, 1, meaning the block can accept a request this cycle.
REQ-013 The block SHALL have port mem_valid, output, 1, meaning a one-cycle completion pulse for reads and writes.
REQ-014 The block SHALL have port mem_rdata, output, BLOCK_SIZE, meaning the refill line, valid when mem_valid=1 for a read.

Function
REQ-015 Storage SHALL be 16 lines x BLOCK_SIZE bits, indexed by mem_addr[7:4], with mem_addr[3:0] ignored.
REQ-016 The FSM SHALL have states IDLE, WAIT and DONE, with mem_ready=1 only in IDLE and mem_valid=1 only in DONE.
REQ-017 In IDLE, at a rising edge with mem_req=1, the block SHALL capture mem_we, the line index and mem_wdata, load cnt=MEM_LATENCY-1 and enter WAIT.
REQ-018 In WAIT, at each edge, the block SHALL enter DONE if cnt==0 and otherwise decrement cnt.
REQ-019 On the edge entering DONE, a captured write SHALL update the line, and a captured read SHALL load the line into mem_rdata.
REQ-020 Latency: for a request accepted at edge N, mem_valid SHALL be high between edge N+MEM_LATENCY and edge N+MEM_LATENCY+1 only.
REQ-021 DONE SHALL always return to IDLE after one cycle, so the next request is accepted no earlier than edge N+MEM_LATENCY+1.
REQ-022 mem_req SHALL be ignored while mem_ready=0, and SHALL NOT be queued.
REQ-023 Changes on mem_we, mem_addr and mem_wdata after acceptance SHALL have no effect on the transfer in flight.
REQ-024 mem_rdata SHALL hold the last read line until the next read completes, and writes SHALL NOT change mem_rdata.
REQ-025 A read of a line written earlier SHALL return the written data, including a read issued back-to-back after the write.
REQ-026 The INIT_MEM=1 pattern SHALL be: byte at address a holds a[7:0], so word 0 of line 1 is 32'h13121110.

Reset
REQ-027 While rst_n=1, the block SHALL immediately force state=IDLE, cnt=0, mem_ready=1, mem_valid=0 and mem_rdata=0.
REQ-028 While rst_n=1, all 16 lines SHALL be re-initialized per INIT_MEM.
REQ-029 Reset asserted during WAIT or DONE SHALL abort the transfer, with no array update and no mem_valid pulse.
REQ-030 After rst_n falls, the first rising edge with mem_req=1 SHALL be accepted.

Verification
REQ-031 Reset release, then read with addr 8'h10, MEM_LATENCY=4 -> mem_valid pulses exactly 4 cycles after acceptance, mem_rdata=128'h1F1E1D1C_1B1A1918_17161514_13121110.
REQ-032 Write of line 0x90 with 128'hCAFEBABE_CAFEBABE_CAFEBABE_CAFEBABE, then read of 8'h9C -> write pulse with mem_rdata unchanged, then the read returns the written line.
REQ-033 mem_req toggled and mem_addr changed during WAIT of a read of 0x30 -> no extra transfer, data returned is line 3 (word 0 = 32'h33323130).
REQ-034 Reset asserted 2 cycles into a write of line 0x70 -> mem_valid stays 0, mem_ready=1, and a later read of 0x70 returns the init pattern (word 0 = 32'h73727170).
REQ-035 MEM_LATENCY=1 with back-to-back reads of 0x00 then 0xF0 -> valid pulses at N+1 and N+3, data word 0 = 32'h03020100 then 32'hF3F2F1F0.
REQ-036 INIT_MEM=0, read of 0x50 -> mem_rdata=0.
